// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage of the 5-stage MIPS core (between EX and WB).
//
// Registers the EX results into the M bank, turns the data SRAM read word into
// the final GPR value for loads (byte/half extraction, sign/zero extension,
// LWL/LWR merge with the old rt value), feeds that value back to ID as the
// MEM-stage bypass, and registers it into the W bank which drives the regfile
// write port and the debug_wb_* trace taps.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   mem_stall_i         hold both M and W banks (and keep the read buffer)
//   mem_flush_i         squash the instruction entering M (becomes a bubble)
//   ex_*                instruction leaving EX: pc, GPR write enable/addr/data,
//                       memory op code, effective address
//   data_sram_rdata     SRAM read word, valid only in the first MEM cycle
//   mem_fwd_*           combinational bypass of the instruction in M
//   wb_*                registered regfile write port
//   debug_wb_*          trace taps mirroring the WB write
module mem_stage #(
  parameter int MMOP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall_i,
  input  logic              mem_flush_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_wren_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [MMOP_W-1:0] ex_memop_i,
  input  logic [31:0]       ex_memaddr_i,
  input  logic [31:0]       data_sram_rdata,
  output logic              mem_fwd_wen_o,
  output logic [4:0]        mem_fwd_waddr_o,
  output logic [31:0]       mem_fwd_wdata_o,
  output logic              wb_wen_o,
  output logic [4:0]        wb_waddr_o,
  output logic [31:0]       wb_wdata_o,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  localparam logic [MMOP_W-1:0] OP_NOP = MMOP_W'(0);
  localparam logic [MMOP_W-1:0] OP_LB  = MMOP_W'(1);
  localparam logic [MMOP_W-1:0] OP_LBU = MMOP_W'(2);
  localparam logic [MMOP_W-1:0] OP_LH  = MMOP_W'(3);
  localparam logic [MMOP_W-1:0] OP_LHU = MMOP_W'(4);
  localparam logic [MMOP_W-1:0] OP_LW  = MMOP_W'(5);
  localparam logic [MMOP_W-1:0] OP_LWL = MMOP_W'(6);
  localparam logic [MMOP_W-1:0] OP_LWR = MMOP_W'(7);

  // M bank
  logic [31:0]       m_pc_reg;
  logic              m_wren_reg;
  logic [4:0]        m_waddr_reg;
  logic [31:0]       m_wdata_reg;
  logic [MMOP_W-1:0] m_memop_reg;
  logic [1:0]        m_addr_reg;

  // W bank
  logic [31:0]       w_pc_reg;
  logic              w_wen_reg;
  logic [4:0]        w_waddr_reg;
  logic [31:0]       w_wdata_reg;

  // Read buffer: the SRAM only presents the word in the first MEM cycle, so a
  // load stalled in M must keep its own copy.
  logic [31:0]       hold_q_reg;
  logic              hold_v_reg;

  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic              m_is_load;
  logic              m_wen_eff;
  logic [31:0]       result;

  assign m_is_load = (m_memop_reg >= OP_LB) && (m_memop_reg <= OP_LWR);
  // r0 is hardwired zero: never advertise a write to it.
  assign m_wen_eff = m_wren_reg && (m_waddr_reg != 5'd0);

  always_comb begin
    rd_word = hold_v_reg ? hold_q_reg : data_sram_rdata;
    rd_half = m_addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (m_addr_reg)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase

    result = m_wdata_reg;
    case (m_memop_reg)
      OP_LB:  result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: result = {24'd0, rd_byte};
      OP_LH:  result = {{16{rd_half[15]}}, rd_half};
      OP_LHU: result = {16'd0, rd_half};
      OP_LW:  result = rd_word;
      // Unaligned-left: low bytes of memory fill the top of rt.
      OP_LWL: begin
        case (m_addr_reg)
          2'd0:    result = {rd_word[7:0],  m_wdata_reg[23:0]};
          2'd1:    result = {rd_word[15:0], m_wdata_reg[15:0]};
          2'd2:    result = {rd_word[23:0], m_wdata_reg[7:0]};
          default: result = rd_word;
        endcase
      end
      // Unaligned-right: high bytes of memory fill the bottom of rt.
      OP_LWR: begin
        case (m_addr_reg)
          2'd0:    result = rd_word;
          2'd1:    result = {m_wdata_reg[31:24], rd_word[31:8]};
          2'd2:    result = {m_wdata_reg[31:16], rd_word[31:16]};
          default: result = {m_wdata_reg[31:8],  rd_word[31:24]};
        endcase
      end
      default: result = m_wdata_reg;
    endcase
  end

  // Stall has priority over flush; reset has priority over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_pc_reg    <= 32'd0;
      m_wren_reg  <= 1'b0;
      m_waddr_reg <= 5'd0;
      m_wdata_reg <= 32'd0;
      m_memop_reg <= OP_NOP;
      m_addr_reg  <= 2'd0;
      w_pc_reg    <= 32'd0;
      w_wen_reg   <= 1'b0;
      w_waddr_reg <= 5'd0;
      w_wdata_reg <= 32'd0;
      hold_q_reg  <= 32'd0;
      hold_v_reg  <= 1'b0;
    end else if (mem_stall_i) begin
      if (m_is_load && !hold_v_reg) begin
        hold_q_reg <= data_sram_rdata;
        hold_v_reg <= 1'b1;
      end
    end else begin
      hold_v_reg  <= 1'b0;
      w_pc_reg    <= m_pc_reg;
      w_wen_reg   <= m_wen_eff;
      w_waddr_reg <= m_waddr_reg;
      w_wdata_reg <= result;
      if (mem_flush_i) begin
        m_pc_reg    <= 32'd0;
        m_wren_reg  <= 1'b0;
        m_waddr_reg <= 5'd0;
        m_wdata_reg <= 32'd0;
        m_memop_reg <= OP_NOP;
        m_addr_reg  <= 2'd0;
      end else begin
        m_pc_reg    <= ex_pc_i;
        m_wren_reg  <= ex_wren_i;
        m_waddr_reg <= ex_waddr_i;
        m_wdata_reg <= ex_wdata_i;
        m_memop_reg <= ex_memop_i;
        m_addr_reg  <= ex_memaddr_i[1:0];
      end
    end
  end

  assign mem_fwd_wen_o     = m_wen_eff;
  assign mem_fwd_waddr_o   = m_waddr_reg;
  assign mem_fwd_wdata_o   = result;

  assign wb_wen_o          = w_wen_reg;
  assign wb_waddr_o        = w_waddr_reg;
  assign wb_wdata_o        = w_wdata_reg;
  assign debug_wb_pc       = w_pc_reg;
  assign debug_wb_rf_wen   = {4{w_wen_reg}};
  assign debug_wb_rf_wnum  = w_waddr_reg;
  assign debug_wb_rf_wdata = w_wdata_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// A reference model tracks the instruction sitting in MEM and the one in WB as
// plain records; load results are computed with shifts and masks on the word
// recorded during the instruction's first MEM cycle.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_stall;
  logic        mem_flush;
  logic [31:0] ex_pc;
  logic        ex_wren;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_memop;
  logic [31:0] ex_memaddr;
  logic [31:0] sram_rdata;
  logic        fwd_wen;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] dbg_pc;
  logic [3:0]  dbg_wen;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;

  mem_stage #(.MMOP_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_stall_i       (mem_stall),
    .mem_flush_i       (mem_flush),
    .ex_pc_i           (ex_pc),
    .ex_wren_i         (ex_wren),
    .ex_waddr_i        (ex_waddr),
    .ex_wdata_i        (ex_wdata),
    .ex_memop_i        (ex_memop),
    .ex_memaddr_i      (ex_memaddr),
    .data_sram_rdata   (sram_rdata),
    .mem_fwd_wen_o     (fwd_wen),
    .mem_fwd_waddr_o   (fwd_waddr),
    .mem_fwd_wdata_o   (fwd_wdata),
    .wb_wen_o          (wb_wen),
    .wb_waddr_o        (wb_waddr),
    .wb_wdata_o        (wb_wdata),
    .debug_wb_pc       (dbg_pc),
    .debug_wb_rf_wen   (dbg_wen),
    .debug_wb_rf_wnum  (dbg_wnum),
    .debug_wb_rf_wdata (dbg_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  memop;
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        first;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] w_pc;
  logic        w_wen;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        started;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_result(input slot_t s);
    int          b;
    logic [31:0] r;
    logic [31:0] o;
    logic [31:0] bv;
    logic [31:0] hv;
    b  = int'(s.addr);
    r  = s.rd;
    o  = s.wdata;
    bv = (r >> (8 * b)) & 32'h0000_00FF;
    hv = (r >> (16 * (b / 2))) & 32'h0000_FFFF;
    case (s.memop)
      4'd1:    return bv[7]  ? (bv | 32'hFFFF_FF00) : bv;
      4'd2:    return bv;
      4'd3:    return hv[15] ? (hv | 32'hFFFF_0000) : hv;
      4'd4:    return hv;
      4'd5:    return r;
      4'd6:    return (r << (8 * (3 - b))) | (o & ((32'h1 << (8 * (3 - b))) - 32'h1));
      4'd7:    return (r >> (8 * b)) | (o & ~(32'hFFFF_FFFF >> (8 * b)));
      default: return o;
    endcase
  endfunction

  // One clock cycle: drive EX-side inputs, check outputs mid-cycle, then
  // advance the model on the edge. rdv is the SRAM word for the instruction
  // currently in MEM; it is only presented in that instruction's first cycle.
  task automatic cycle(input logic r, input logic st, input logic fl,
                       input logic [31:0] pc, input logic wren, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] op,
                       input logic [31:0] addr, input logic [31:0] rdv);
    logic [31:0] res;
    rst        = r;
    mem_stall  = st;
    mem_flush  = fl;
    ex_pc      = pc;
    ex_wren    = wren;
    ex_waddr   = wa;
    ex_wdata   = wd;
    ex_memop   = op;
    ex_memaddr = addr;
    if (m_slot.first) begin
      m_slot.rd  = rdv;
      sram_rdata = rdv;
    end else begin
      sram_rdata = $urandom;
    end

    @(negedge clk);
    res = model_result(m_slot);
    if (started) begin
      check("fwd_wen",   32'(fwd_wen),   32'(m_slot.wren && (m_slot.waddr != 5'd0)));
      check("fwd_waddr", 32'(fwd_waddr), 32'(m_slot.waddr));
      check("fwd_wdata", fwd_wdata,      res);
      check("wb_wen",    32'(wb_wen),    32'(w_wen));
      check("wb_waddr",  32'(wb_waddr),  32'(w_waddr));
      check("wb_wdata",  wb_wdata,       w_wdata);
      check("dbg_pc",    dbg_pc,         w_pc);
      check("dbg_wen",   32'(dbg_wen),   w_wen ? 32'hF : 32'h0);
      check("dbg_wnum",  32'(dbg_wnum),  32'(w_waddr));
      check("dbg_wdata", dbg_wdata,      w_wdata);
    end

    @(posedge clk);
    if (r) begin
      m_slot  = '{pc: 32'd0, wren: 1'b0, waddr: 5'd0, wdata: 32'd0, memop: 4'd0,
                  addr: 2'd0, rd: 32'd0, first: 1'b0};
      w_pc    = 32'd0;
      w_wen   = 1'b0;
      w_waddr = 5'd0;
      w_wdata = 32'd0;
      started = 1'b1;
    end else if (!st) begin
      w_pc    = m_slot.pc;
      w_wen   = m_slot.wren && (m_slot.waddr != 5'd0);
      w_waddr = m_slot.waddr;
      w_wdata = res;
      if (fl)
        m_slot = '{pc: 32'd0, wren: 1'b0, waddr: 5'd0, wdata: 32'd0, memop: 4'd0,
                   addr: 2'd0, rd: 32'd0, first: 1'b1};
      else
        m_slot = '{pc: pc, wren: wren, waddr: wa, wdata: wd, memop: op,
                   addr: addr[1:0], rd: 32'd0, first: 1'b1};
    end else begin
      m_slot.first = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [3:0] op;
    n_checks   = 0;
    n_fail     = 0;
    started    = 1'b0;
    m_slot     = '{pc: 32'd0, wren: 1'b0, waddr: 5'd0, wdata: 32'd0, memop: 4'd0,
                   addr: 2'd0, rd: 32'd0, first: 1'b0};
    w_pc = 32'd0; w_wen = 1'b0; w_waddr = 5'd0; w_wdata = 32'd0;
    rst = 1'b1; mem_stall = 1'b0; mem_flush = 1'b0;
    ex_pc = 32'd0; ex_wren = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    ex_memop = 4'd0; ex_memaddr = 32'd0; sram_rdata = 32'd0;
    @(posedge clk);
    #1;

    // Reset held two cycles, then reset state checked in the next cycle.
    cycle(1, 0, 0, 32'h0, 0, 5'd0, 32'h0, 4'd0, 32'h0, 32'h0);
    cycle(1, 1, 0, 32'h0, 0, 5'd0, 32'h0, 4'd0, 32'h0, 32'h0);

    // Directed loads: each rdv is the word for the op issued one call earlier.
    cycle(0, 0, 0, 32'h100, 1, 5'd5,  32'h0,         4'd1, 32'h1001, 32'h0);
    cycle(0, 0, 0, 32'h104, 1, 5'd6,  32'h0,         4'd4, 32'h1002, 32'h1234_80FF);
    cycle(0, 0, 0, 32'h108, 1, 5'd7,  32'h0,         4'd3, 32'h1002, 32'h8001_0000);
    cycle(0, 0, 0, 32'h10C, 1, 5'd8,  32'hAABB_CCDD, 4'd6, 32'h1001, 32'h8001_0000);
    cycle(0, 0, 0, 32'h110, 1, 5'd9,  32'hAABB_CCDD, 4'd7, 32'h1002, 32'h1122_3344);
    cycle(0, 0, 0, 32'h114, 1, 5'd10, 32'h0,         4'd5, 32'h2000, 32'h1122_3344);
    // LW stalled three cycles; SRAM word becomes garbage after the first.
    cycle(0, 1, 0, 32'h118, 1, 5'd11, 32'h5555,      4'd0, 32'h0,    32'hCAFE_BABE);
    cycle(0, 1, 0, 32'h118, 1, 5'd11, 32'h5555,      4'd0, 32'h0,    32'h0);
    cycle(0, 1, 0, 32'h118, 1, 5'd11, 32'h5555,      4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h118, 1, 5'd11, 32'h5555,      4'd0, 32'h0,    32'h0);
    // Flushed ALU op to r7, ALU op to r0, then back-to-back ALU ops.
    cycle(0, 0, 1, 32'h11C, 1, 5'd7,  32'hDEAD,      4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h120, 1, 5'd0,  32'hBEEF,      4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h124, 1, 5'd12, 32'h1111,      4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h128, 1, 5'd13, 32'h2222,      4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h12C, 0, 5'd0,  32'h0,         4'd0, 32'h0,    32'h0);
    cycle(0, 0, 0, 32'h130, 0, 5'd0,  32'h0,         4'd0, 32'h0,    32'h0);

    // Randomized traffic including stalls, flushes and occasional reset.
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 10));
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            $urandom,
            (op >= 4'd8) ? 1'b0 : ($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 31)),
            $urandom,
            op,
            $urandom,
            $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
